note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Arpeggiator/scheduler behind switch_to_note. Snapshots one 8-slot chord (notes bus + switch mask),
//  then plays each enabled slot's 6-bit note to the downstream tone generator, lowest slot first.
//  Transfers use a valid/ready handshake. A programmable gap of step_period clocks follows each accepted note.
// PARAMETERS
//  NOTE_W   6   bits per note; slot k = notes[k*NOTE_W +: NOTE_W]
//  SLOTS    8   number of slots; also the width of the switches mask
//  CNT_W    24  width of the step_period input and of the gap counter
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous reset, active low
//  start        in   1              level-sampled request to play the current chord
//  stop         in   1              abort; takes priority over every other input
//  step_period  in   CNT_W          gap length in clocks after each accepted note; value 0 is treated as 1
//  notes        in   NOTE_W*SLOTS   note bus from switch_to_note
//  switches     in   SLOTS          slot enable mask; bit k enables slot k
//  note_out     out  NOTE_W         note currently offered
//  note_valid   out  1              note_out is valid
//  note_ready   in   1              downstream accepts the note when note_valid && note_ready at a clock edge
//  slot_idx     out  3              slot index of note_out
//  busy         out  1              high whenever the state is not IDLE
//  chord_done   out  1              one-cycle pulse at the end of a pass
// BEHAVIOUR
//  - Reset (async): state=IDLE. All outputs 0. Shadow registers, remaining-mask register and counter cleared.
//  - States: IDLE, EMIT, GAP. All outputs are registered.
//  - IDLE, start=1, stop=0 at edge E:
//      - Latch notes into shadow_notes and switches into rem_mask.
//      - Latch step_period into per_q, forcing 0 to 1.
//      - If the mask is nonzero: state=EMIT, and note_valid=1 is visible after E.
//        slot_idx = lowest set bit of the mask; note_out = that slot's shadow note.
//      - If the mask is zero: chord_done=1 for the cycle after E; state stays IDLE.
//  - EMIT: note_out and slot_idx stay stable and note_valid stays high until accepted. There is no timeout.
//  - Accept edge A (in EMIT):
//      - Clear bit slot_idx in rem_mask; note_valid=0.
//      - cnt = per_q-1; state=GAP.
//  - GAP: cnt decrements each edge. At the edge where cnt==0:
//      - If rem_mask != 0: state=EMIT with the next lowest set slot; note_valid=1 again at edge A+per_q.
//      - If rem_mask == 0: end of pass. chord_done is pulsed for 1 cycle and state=IDLE
//        (see CONFIGURATION for the loop case).
//      - So note_valid is low for exactly per_q cycles between notes. The final note also gets its gap
//        before chord_done.
//  - Inputs notes, switches and step_period are ignored outside the start edge. Changing them mid-pass has no effect.
//  - start while busy is ignored.
//  - stop=1 in any state at edge E:
//      - state=IDLE, note_valid=0, rem_mask=0, no chord_done.
//      - An un-accepted note is dropped, even if note_ready=1 at the same edge.
//  - start and stop together at an IDLE edge: stop wins; nothing is latched.
//  - busy = (state != IDLE), registered with the state.
//  - Async reset mid-pass: everything returns to reset values immediately. No pulse is emitted.
// CONFIGURATION
//  - NOTE_SEQ_LOOP_EN defined:
//      - End of pass does not go to IDLE. It still pulses chord_done.
//      - It re-snapshots notes, switches and step_period at that same edge and continues as a fresh start.
//      - If the fresh mask is zero: go to IDLE.
//      - This repeats until stop is asserted.
//  - NOTE_SEQ_LOOP_EN not defined: single pass, then IDLE, as described above.
// TESTING
//  1. notes slot k = k+10, switches=8'b10100010, step_period=4, note_ready=1, start pulse.
//     -> note_out 11, 15, 17 (slot_idx 1, 5, 7) in that order.
//     -> valid edges 5 cycles apart (1-cycle accept + 4-cycle gap).
//     -> chord_done 4 cycles after the third accept; busy low after that.
//  2. switches=8'b00000000, start.
//     -> chord_done high for 1 cycle; note_valid never high; busy stays 0.
//  3. switches=8'b10000000, note_ready held 0 for 10 cycles, then 1.
//     -> note_out=17 and slot_idx=7 stable the whole time; accepted once, no duplicate.
//  4. switches=8'b11111111, step_period=0.
//     -> 8 notes 10..17; 1-cycle gap each; step_period=0 behaves as 1.
//  5. Mid-pass: stop asserted while note_valid=1 and note_ready=1.
//     -> note_valid=0 next cycle, busy=0, no chord_done.
//     -> Changing switches during a pass does not alter the sequence.
//  6. NOTE_SEQ_LOOP_EN, switches=8'b00110000.
//     -> 14, 15, chord_done, 14, 15, ... until stop.
//     -> Setting switches=0 mid-pass gives IDLE at the next wrap.

Source files
------------

// File: rtl/note_sequencer.sv
// Chord arpeggiator: snapshots an 8-slot chord and plays its enabled slots lowest-first over valid/ready.
// Optional define NOTE_SEQ_LOOP_EN: re-snapshot and replay at the end of every pass until stop.
module note_sequencer #(
   parameter int NOTE_W = 6,
   parameter int SLOTS  = 8,
   parameter int CNT_W  = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [CNT_W-1:0]        step_period,
   input  logic [NOTE_W*SLOTS-1:0] notes,
   input  logic [SLOTS-1:0]        switches,
   output logic [NOTE_W-1:0]       note_out,
   output logic                    note_valid,
   input  logic                    note_ready,
   output logic [$clog2(SLOTS)-1:0] slot_idx,
   output logic                    busy,
   output logic                    chord_done
);

   localparam int IDX_W = $clog2(SLOTS);

   typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

   state_t                  r_state, w_state_nxt;
   logic [NOTE_W*SLOTS-1:0] r_shadow, w_shadow_nxt;
   logic [SLOTS-1:0]        r_rem, w_rem_nxt;
   logic [CNT_W-1:0]        r_per, w_per_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [NOTE_W-1:0]       r_note, w_note_nxt;
   logic [IDX_W-1:0]        r_slot, w_slot_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_done, w_done_nxt;
   logic                    r_busy;
   logic                    w_load;
   logic [IDX_W-1:0]        w_first;
   logic [IDX_W-1:0]        w_next;

   function automatic logic [IDX_W-1:0] lowest(input logic [SLOTS-1:0] m);
      lowest = '0;
      for (int unsigned i = SLOTS; i > 0; i--) begin
         if (m[i-1]) lowest = IDX_W'(i - 1);
      end
   endfunction

   assign w_first = lowest(switches);
   assign w_next  = lowest(r_rem);

   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_rem_nxt    = r_rem;
      w_per_nxt    = r_per;
      w_cnt_nxt    = r_cnt;
      w_note_nxt   = r_note;
      w_slot_nxt   = r_slot;
      w_valid_nxt  = r_valid;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;

      if (stop) begin
         w_state_nxt = IDLE;
         w_valid_nxt = 1'b0;
         w_rem_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: w_load = start;
            EMIT: begin
               if (note_ready) begin
                  w_rem_nxt[r_slot] = 1'b0;
                  w_valid_nxt       = 1'b0;
                  w_cnt_nxt         = r_per - CNT_W'(1);
                  w_state_nxt       = GAP;
               end
            end
            GAP: begin
               if (r_cnt == '0) begin
                  if (r_rem != '0) begin
                     w_state_nxt = EMIT;
                     w_slot_nxt  = w_next;
                     w_note_nxt  = r_shadow[w_next*NOTE_W +: NOTE_W];
                     w_valid_nxt = 1'b1;
                  end else begin
                     w_done_nxt  = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                     w_load      = 1'b1;
`else
                     w_state_nxt = IDLE;
`endif
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            default: w_state_nxt = IDLE;
         endcase

         // Snapshot is shared by a fresh start and by the loop-mode wrap
         if (w_load) begin
            w_shadow_nxt = notes;
            w_rem_nxt    = switches;
            w_per_nxt    = (step_period == '0) ? CNT_W'(1) : step_period;
            if (switches != '0) begin
               w_state_nxt = EMIT;
               w_slot_nxt  = w_first;
               w_note_nxt  = notes[w_first*NOTE_W +: NOTE_W];
               w_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_shadow <= '0;
         r_rem    <= '0;
         r_per    <= '0;
         r_cnt    <= '0;
         r_note   <= '0;
         r_slot   <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_rem    <= w_rem_nxt;
         r_per    <= w_per_nxt;
         r_cnt    <= w_cnt_nxt;
         r_note   <= w_note_nxt;
         r_slot   <= w_slot_nxt;
         r_valid  <= w_valid_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= (w_state_nxt != IDLE);
      end
   end

   assign note_out   = r_note;
   assign note_valid = r_valid;
   assign slot_idx   = r_slot;
   assign busy       = r_busy;
   assign chord_done = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a chord model queues expected (slot, note) transfers,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [23:0] step_period;
   logic [47:0] notes;
   logic [7:0]  switches;
   logic [5:0]  note_out;
   logic        note_valid;
   logic        note_ready;
   logic [2:0]  slot_idx;
   logic        busy;
   logic        chord_done;

   typedef struct {
      logic [2:0] slot;
      logic [5:0] note;
   } exp_t;

   exp_t exp_q[$];
   int   acc_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   int   act_done;
   int   exp_done = 0;
   int   done_cyc;
   int   valid_seen;
   int   busy_seen;
   int   ready_mode = 1;
   int   start_cyc;

   note_sequencer #(.NOTE_W(6), .SLOTS(8), .CNT_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .step_period(step_period), .notes(notes), .switches(switches),
      .note_out(note_out), .note_valid(note_valid), .note_ready(note_ready),
      .slot_idx(slot_idx), .busy(busy), .chord_done(chord_done)
   );

   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      note_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       note_ready = 1'b0;
            1:       note_ready = 1'b1;
            default: note_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one transfer per enabled slot, lowest slot first, plus one done pulse per pass
   task automatic push_model(input logic [47:0] n, input logic [7:0] sw);
      for (int k = 0; k < 8; k++) begin
         if (sw[k]) exp_q.push_back('{slot: 3'(k), note: n[k*6 +: 6]});
      end
      exp_done++;
   endtask

   function automatic logic [47:0] ramp_notes();
      logic [47:0] n;
      for (int k = 0; k < 8; k++) n[k*6 +: 6] = 6'(k + 10);
      return n;
   endfunction

   initial begin
      exp_t e;
      logic prev_done;
      act_done = 0; done_cyc = 0; valid_seen = 0; busy_seen = 0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (note_valid && note_ready && !stop) begin
               acc_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_accept: got note %0d slot %0d expected no transfer", note_out, slot_idx);
               end else begin
                  e = exp_q.pop_front();
                  check("note_out", note_out, e.note);
                  check("slot_idx", slot_idx, e.slot);
               end
            end
            if (chord_done) begin
               act_done++;
               done_cyc = cyc;
               check("done_pulse_width", prev_done, 0);
            end
            if (note_valid) valid_seen++;
            if (busy) busy_seen++;
            prev_done = chord_done;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   task automatic wait_idle(input bit scramble);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!busy && !note_valid && exp_q.size() == 0 && act_done == exp_done) begin
            ok = 1'b1;
            break;
         end
         if (scramble) begin
            notes       = {$urandom, $urandom};
            switches    = 8'($urandom);
            step_period = 24'($urandom);
         end
      end
      check("pass_complete", ok, 1);
      check("done_count", act_done, exp_done);
   endtask

   task automatic issue_start(input logic [47:0] n, input logic [7:0] sw, input logic [23:0] per);
      @(posedge clk);
      #1;
      notes = n; switches = sw; step_period = per; start = 1'b1;
      start_cyc = cyc;
      acc_cyc.delete();
      push_model(n, sw);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      int vb;
      int bb;
      int db;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_period = '0; notes = '0; switches = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_note_out", note_out, 0);
      check("rst_note_valid", note_valid, 0);
      check("rst_slot_idx", slot_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_chord_done", chord_done, 0);
      #2 rst_n = 1'b1;

      // three sparse slots, gap 4
      ready_mode = 1;
      issue_start(ramp_notes(), 8'b10100010, 24'd4);
      wait_idle(1'b0);
      check("t1_accepts", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         check("t1_first_latency", acc_cyc[0] - start_cyc, 1);
         check("t1_interval_a", acc_cyc[1] - acc_cyc[0], 5);
         check("t1_interval_b", acc_cyc[2] - acc_cyc[1], 5);
         check("t1_done_delay", done_cyc - acc_cyc[2], 5);
      end

      // empty mask: immediate done, never busy or valid
      vb = valid_seen; bb = busy_seen;
      issue_start(ramp_notes(), 8'h00, 24'd3);
      wait_idle(1'b0);
      check("t2_valid_seen", valid_seen - vb, 0);
      check("t2_busy_seen", busy_seen - bb, 0);
      check("t2_done_latency", done_cyc - start_cyc, 1);

      // back-pressure: offer must hold steady
      @(negedge clk);
      ready_mode = 0;
      issue_start(ramp_notes(), 8'h80, 24'd2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_valid", note_valid, 1);
         check("t3_hold_note", note_out, 17);
         check("t3_hold_slot", slot_idx, 7);
      end
      ready_mode = 1;
      wait_idle(1'b0);
      check("t3_accepts", acc_cyc.size(), 1);

      // all slots, period 0 behaves as 1
      issue_start(ramp_notes(), 8'hFF, 24'd0);
      wait_idle(1'b0);
      check("t4_accepts", acc_cyc.size(), 8);
      if (acc_cyc.size() == 8) begin
         for (int i = 1; i < 8; i++) check("t4_interval", acc_cyc[i] - acc_cyc[i-1], 2);
      end

      // stop while a note is offered with ready high
      issue_start(ramp_notes(), 8'hFF, 24'd1);
      for (int i = 0; i < 200 && acc_cyc.size() < 3; i++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (note_valid) begin
            stop = 1'b1;
            switches = 8'h00;
            break;
         end
      end
      db = act_done;
      @(posedge clk);
      #1;
      stop = 1'b0;
      check("t5_valid_after_stop", note_valid, 0);
      check("t5_busy_after_stop", busy, 0);
      exp_q.delete();
      exp_done--;
      repeat (6) @(negedge clk);
      check("t5_no_done", act_done, db);
      check("t5_accepts", acc_cyc.size(), 3);

      // async reset mid-pass
      issue_start(ramp_notes(), 8'hFF, 24'd2);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("ar_valid", note_valid, 0);
      check("ar_busy", busy, 0);
      check("ar_note_out", note_out, 0);
      check("ar_slot_idx", slot_idx, 0);
      exp_q.delete();
      exp_done--;
      db = act_done;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("ar_no_done", act_done, db);

      // randomized chords, random back-pressure, inputs scrambled mid-pass
      ready_mode = 2;
      for (int p = 0; p < 20; p++) begin
         issue_start({$urandom, $urandom}, 8'($urandom), 24'($urandom_range(0, 3)));
         wait_idle(1'b1);
      end
      ready_mode = 1;

`ifdef NOTE_SEQ_LOOP_EN
      // loop mode: three passes, then a zero mask ends it at the wrap
      issue_start(ramp_notes(), 8'b00110000, 24'd1);
      push_model(ramp_notes(), 8'b00110000);
      push_model(ramp_notes(), 8'b00110000);
      db = act_done;
      for (int i = 0; i < 400 && act_done < db + 2; i++) begin
         @(posedge clk);
         #1;
      end
      switches = 8'h00;
      wait_idle(1'b0);
      check("loop_accepts_last_pass", acc_cyc.size(), 6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
